// File: rtl/clkdiv_ctrl.sv
// Multi-channel clock-enable divider; run-time period/width changes go through shadow registers.
// Optional sticky write-overrun flag (cfg_err / err_clr) when CLKDIV_CTRL_ERR_EN is defined.

module clkdiv_ch #(
    parameter int W          = 26,
    parameter int DEF_PERIOD = 50000000
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         ena,
    input  logic         wr,
    input  logic [W-1:0] wr_period,
    input  logic [W-1:0] wr_high,
    input  logic         wr_oneshot,
    output logic         pending,
    output logic         gen,
    output logic         tick,
    output logic         busy
);
    localparam logic [W-1:0] DEF_P = W'(DEF_PERIOD);
    localparam logic [W-1:0] DEF_H = W'(DEF_PERIOD >> 1);
    localparam logic [W-1:0] MIN_P = W'(2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] period, high, sh_period, sh_high;
    logic         oneshot, sh_oneshot;
    logic         gen_nxt, tick_nxt;
    logic         at_wrap, apply;
    logic [W-1:0] eff_high, new_period;

    assign at_wrap    = (state == RUN) && (cnt == period - 1'b1);
    assign apply      = pending && ((state != RUN) || at_wrap);
    assign new_period = (sh_period < MIN_P) ? MIN_P : sh_period;
    // The period that starts on an apply edge already uses the new width.
    assign eff_high   = apply ? sh_high : high;
    assign busy       = (state == RUN);

    // A write is only accepted while nothing is pending, so wr and apply never coincide.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            period     <= DEF_P;
            high       <= DEF_H;
            oneshot    <= 1'b0;
            sh_period  <= '0;
            sh_high    <= '0;
            sh_oneshot <= 1'b0;
            pending    <= 1'b0;
        end else if (wr) begin
            sh_period  <= wr_period;
            sh_high    <= wr_high;
            sh_oneshot <= wr_oneshot;
            pending    <= 1'b1;
        end else if (apply) begin
            period     <= new_period;
            high       <= sh_high;
            oneshot    <= sh_oneshot;
            pending    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            cnt   <= '0;
            gen   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gen   <= gen_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gen_nxt   = 1'b0;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (ena) begin
                    state_nxt = RUN;
                    tick_nxt  = 1'b1;
                    gen_nxt   = (eff_high != '0);
                end
            end
            RUN: begin
                // Dropping ena abandons the period, even on the wrap edge.
                if (!ena) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (at_wrap && oneshot) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = at_wrap ? '0 : cnt + 1'b1;
                    tick_nxt = at_wrap;
                    gen_nxt  = (cnt_nxt < eff_high);
                end
            end
            DONE: begin
                cnt_nxt = '0;
                if (!ena) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

module clkdiv_ctrl #(
    parameter int  CH         = 4,
    parameter int  W          = 26,
    parameter int  DEF_PERIOD = 50000000,
    localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_period,
    input  logic [W-1:0]  cfg_high,
    input  logic          cfg_oneshot,
    input  logic [CH-1:0] ch_ena,
    output logic [CH-1:0] gen,
    output logic [CH-1:0] tick,
    output logic [CH-1:0] busy,
    output logic          cfg_err,
    input  logic          err_clr
);
    localparam int NP = 1 << CW;

    logic [CH-1:0] pending;
    logic [NP-1:0] pend_ext;
    logic          accept;

    // Channel numbers past CH read as not pending, so those writes are taken and dropped.
    assign pend_ext  = NP'(pending);
    assign cfg_ready = !pend_ext[cfg_ch];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clkdiv_ch #(
            .W          (W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_       (rst_),
            .ena        (ch_ena[i]),
            .wr         (accept && (cfg_ch == CW'(i))),
            .wr_period  (cfg_period),
            .wr_high    (cfg_high),
            .wr_oneshot (cfg_oneshot),
            .pending    (pending[i]),
            .gen        (gen[i]),
            .tick       (tick[i]),
            .busy       (busy[i])
        );
    end

`ifdef CLKDIV_CTRL_ERR_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)                       cfg_err <= 1'b0;
        else if (cfg_valid && !cfg_ready) cfg_err <= 1'b1;
        else if (err_clr)                cfg_err <= 1'b0;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign cfg_err        = 1'b0;
`endif
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: directed scenarios plus random traffic against a per-period channel model.
module tb_clkdiv_ctrl;
    localparam int CH = 4;
    localparam int W  = 16;
    localparam int DP = 10;
    localparam int CW = 2;

    logic          clk, rst_;
    logic          cfg_valid, cfg_ready, cfg_oneshot, cfg_err, err_clr;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_period, cfg_high;
    logic [CH-1:0] ch_ena, gen, tick, busy;

    int errors = 0;
    int checks = 0;

    clkdiv_ctrl #(.CH(CH), .W(W), .DEF_PERIOD(DP)) dut (
        .clk(clk), .rst_(rst_), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_high(cfg_high),
        .cfg_oneshot(cfg_oneshot), .ch_ena(ch_ena), .gen(gen), .tick(tick),
        .busy(busy), .cfg_err(cfg_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle / 1 running / 2 finished oneshot; pos = cycles into the current period.
    int m_mode[CH], m_pos[CH], m_aper[CH], m_ahigh[CH], m_sper[CH], m_shigh[CH];
    bit m_aone[CH], m_sone[CH], m_pend[CH];
    bit m_err;

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0; m_pos[c] = 0; m_aper[c] = DP; m_ahigh[c] = DP / 2; m_aone[c] = 0;
            m_sper[c] = 0; m_shigh[c] = 0; m_sone[c] = 0; m_pend[c] = 0;
        end
        m_err = 0;
    endtask

    function automatic bit m_ready();
        return (int'(cfg_ch) >= CH) ? 1'b1 : !m_pend[int'(cfg_ch)];
    endfunction

    function automatic logic [3*CH-1:0] m_out();
        logic [CH-1:0] g, t, b;
        for (int c = 0; c < CH; c++) begin
            b[c] = (m_mode[c] == 1);
            t[c] = b[c] && (m_pos[c] == 0);
            g[c] = b[c] && (m_pos[c] < m_ahigh[c]);
        end
        return {g, t, b};
    endfunction

    task automatic m_update(input bit rdy);
        for (int c = 0; c < CH; c++) begin
            bit wrap, apply, was_one;
            wrap    = (m_mode[c] == 1) && (m_pos[c] == m_aper[c] - 1);
            apply   = m_pend[c] && (m_mode[c] != 1 || wrap);
            was_one = m_aone[c];
            if (apply) begin
                m_aper[c]  = (m_sper[c] < 2) ? 2 : m_sper[c];
                m_ahigh[c] = m_shigh[c];
                m_aone[c]  = m_sone[c];
                m_pend[c]  = 0;
            end
            if (m_mode[c] == 0) begin
                if (ch_ena[c]) begin m_mode[c] = 1; m_pos[c] = 0; end
            end else if (m_mode[c] == 1) begin
                if (!ch_ena[c]) m_mode[c] = 0;
                else if (wrap) begin
                    if (was_one) m_mode[c] = 2;
                    else m_pos[c] = 0;
                end else m_pos[c]++;
            end else if (!ch_ena[c]) m_mode[c] = 0;
        end
        if (cfg_valid && rdy && int'(cfg_ch) < CH) begin
            m_sper[int'(cfg_ch)]  = int'(cfg_period);
            m_shigh[int'(cfg_ch)] = int'(cfg_high);
            m_sone[int'(cfg_ch)]  = cfg_oneshot;
            m_pend[int'(cfg_ch)]  = 1;
        end
`ifdef CLKDIV_CTRL_ERR_EN
        if (cfg_valid && !rdy) m_err = 1;
        else if (err_clr) m_err = 0;
`endif
    endtask

    // Inputs are stable from the previous negedge; advance DUT and model by one edge.
    task automatic step();
        bit rdy;
        rdy = m_ready();
        @(posedge clk);
        m_update(rdy);
        @(negedge clk);
    endtask

    task automatic clr_in();
        cfg_valid = 0; cfg_ch = '0; cfg_period = '0; cfg_high = '0; cfg_oneshot = 0;
        err_clr = 0; ch_ena = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 0;
        clr_in();
        m_reset();
        @(negedge clk);
        rst_ = 1;
    endtask

    task automatic test_reset();
        rst_ = 0;
        clr_in();
        m_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({gen, tick, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {gen, tick, busy});
        end
        checks++;
        if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL reset_cfg got ready=%b err=%b exp ready=1 err=0", cfg_ready, cfg_err);
        end
        rst_ = 1;
    endtask

    task automatic test_basic();
        int c;
        bit et, eg;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ch_ena[0] = (i >= 5);
            step();
            c  = i + 1;
            et = (c >= 6) && ((c - 6) % 10 == 0);
            eg = (c >= 6) && ((c - 6) % 10 < 5);
            checks++;
            if (tick[0] !== et || gen[0] !== eg) begin
                errors++; $display("FAIL basic cyc%0d got tick=%b gen=%b exp tick=%b gen=%b", c, tick[0], gen[0], et, eg);
            end
            checks++;
            if ({gen, tick, busy} !== m_out()) begin
                errors++; $display("FAIL basic_model cyc%0d got %h exp %h", c, {gen, tick, busy}, m_out());
            end
        end
    endtask

    task automatic test_reconfig();
        int c;
        bit et, eg, er;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            ch_ena = 4'b0010;
            cfg_ch = 2'd1; cfg_period = 16'd4; cfg_high = 16'd1; cfg_oneshot = 0;
            cfg_valid = (i == 3);
            #1;
            er = !(i >= 4 && i <= 10);
            checks++;
            if (cfg_ready !== er) begin
                errors++; $display("FAIL reconfig_ready cyc%0d got %b exp %b", i, cfg_ready, er);
            end
            step();
            c  = i + 1;
            et = (c == 1) || (c >= 11 && (c - 11) % 4 == 0);
            eg = (c >= 1 && c <= 5) || (c >= 11 && (c - 11) % 4 == 0);
            checks++;
            if (tick[1] !== et || gen[1] !== eg) begin
                errors++; $display("FAIL reconfig cyc%0d got tick=%b gen=%b exp tick=%b gen=%b", c, tick[1], gen[1], et, eg);
            end
            checks++;
            if ({gen, tick, busy} !== m_out()) begin
                errors++; $display("FAIL reconfig_model cyc%0d got %h exp %h", c, {gen, tick, busy}, m_out());
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_overrun();
        int c;
        bit et, ee, er;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            ch_ena = 4'b0010;
            cfg_ch = 2'd1; cfg_oneshot = 0;
            cfg_valid = (i == 2) || (i == 3) || (i == 12) || (i == 13);
            cfg_period = (i == 2) ? 16'd4 : (i == 12) ? 16'd5 : 16'd7;
            cfg_high   = (i == 2) ? 16'd1 : (i == 12) ? 16'd2 : 16'd3;
            err_clr = (i == 8) || (i == 13);
            #1;
            er = !((i >= 3 && i <= 10) || (i >= 13 && i <= 14));
            checks++;
            if (cfg_ready !== er) begin
                errors++; $display("FAIL overrun_ready cyc%0d got %b exp %b", i, cfg_ready, er);
            end
            step();
            c  = i + 1;
            et = (c == 1) || (c == 11) || (c == 15) || (c == 20);
`ifdef CLKDIV_CTRL_ERR_EN
            ee = (c >= 4 && c <= 8) || (c >= 14);
`else
            ee = 0;
`endif
            checks++;
            if (tick[1] !== et || cfg_err !== ee) begin
                errors++; $display("FAIL overrun cyc%0d got tick=%b err=%b exp tick=%b err=%b", c, tick[1], cfg_err, et, ee);
            end
            checks++;
            if ({gen, tick, busy} !== m_out() || cfg_err !== m_err) begin
                errors++; $display("FAIL overrun_model cyc%0d got %h/%b exp %h/%b", c, {gen, tick, busy}, cfg_err, m_out(), m_err);
            end
        end
        cfg_valid = 0; err_clr = 1;
        step();
        err_clr = 0;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++; $display("FAIL overrun_clear got %b exp 0", cfg_err);
        end
    endtask

    task automatic test_clamp();
        int c;
        bit et, eg;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cfg_ch = 2'd2; cfg_period = 16'd0; cfg_high = 16'd5; cfg_oneshot = 0;
            cfg_valid = (i == 0);
            ch_ena[2] = (i >= 3);
            step();
            c  = i + 1;
            et = (c >= 4) && ((c - 4) % 2 == 0);
            eg = (c >= 4);
            checks++;
            if (tick[2] !== et || gen[2] !== eg || busy[2] !== eg) begin
                errors++; $display("FAIL clamp cyc%0d got t/g/b=%b%b%b exp %b%b%b", c, tick[2], gen[2], busy[2], et, eg, eg);
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_oneshot();
        int c;
        bit et, eb;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            cfg_ch = 2'd3; cfg_period = 16'd6; cfg_high = 16'd2; cfg_oneshot = 1;
            cfg_valid = (i == 0);
            ch_ena[3] = (i >= 2 && i < 20) || (i >= 21);
            step();
            c  = i + 1;
            et = (c == 3) || (c == 22);
            eb = (c >= 3 && c <= 8) || (c >= 22);
            checks++;
            if (tick[3] !== et || busy[3] !== eb) begin
                errors++; $display("FAIL oneshot cyc%0d got tick=%b busy=%b exp tick=%b busy=%b", c, tick[3], busy[3], et, eb);
            end
            checks++;
            if ({gen, tick, busy} !== m_out()) begin
                errors++; $display("FAIL oneshot_model cyc%0d got %h exp %h", c, {gen, tick, busy}, m_out());
            end
        end
        cfg_valid = 0; cfg_oneshot = 0;
    endtask

    task automatic test_async_reset();
        int c;
        bit [1:0] et;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ch_ena = 4'b0011;
            cfg_ch = 2'd1; cfg_period = 16'd4; cfg_high = 16'd1;
            cfg_valid = (i == 2);
            step();
        end
        cfg_valid = 0;
        checks++;
        if (busy[1:0] !== 2'b11 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL areset_pre got busy=%b ready=%b exp busy=11 ready=0", busy[1:0], cfg_ready);
        end
        #2 rst_ = 0;
        #1;
        checks++;
        if ({gen, tick, busy} !== '0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL areset got out=%h ready=%b err=%b exp 0/1/0", {gen, tick, busy}, cfg_ready, cfg_err);
        end
        m_reset();
        @(negedge clk);
        rst_ = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            c  = i + 1;
            et = ((c == 1) || (c == 11)) ? 2'b11 : 2'b00;
            checks++;
            if (tick[1:0] !== et) begin
                errors++; $display("FAIL areset_restart cyc%0d got %b exp %b", c, tick[1:0], et);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(15) == 0) ch_ena[c] = !ch_ena[c];
            cfg_valid   = ($urandom_range(3) == 0);
            cfg_ch      = CW'($urandom_range(CH - 1));
            cfg_period  = W'($urandom_range(12));
            cfg_high    = W'($urandom_range(14));
            cfg_oneshot = ($urandom_range(3) == 0);
            err_clr     = ($urandom_range(7) == 0);
            #1;
            checks++;
            if (cfg_ready !== m_ready()) begin
                errors++; $display("FAIL random_ready it%0d got %b exp %b", i, cfg_ready, m_ready());
            end
            step();
            checks++;
            if ({gen, tick, busy} !== m_out()) begin
                errors++; $display("FAIL random_out it%0d got %h exp %h", i, {gen, tick, busy}, m_out());
            end
            checks++;
            if (cfg_err !== m_err) begin
                errors++; $display("FAIL random_err it%0d got %b exp %b", i, cfg_err, m_err);
            end
        end
        clr_in();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_overrun();
        test_clamp();
        test_oneshot();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
